// File: rtl/otp_ctrl_lci_multi.sv
// Life cycle payload programmer: burns NumWords OTP words one at a time, skipping
// blank words, with optional read-back verify and bounded per-word retries.
module otp_ctrl_lci_multi #(
  parameter int                   NumWords   = 12,
  parameter int                   WordWidth  = 16,
  parameter int                   AddrWidth  = 10,
  parameter logic [AddrWidth-1:0] BaseAddr   = '0,
  parameter bit                   VerifyEn   = 1'b1,
  parameter int                   MaxRetries = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          en_i,
  input  logic [3:0]                    escalate_en_i,
  input  logic                          req_i,
  input  logic [NumWords*WordWidth-1:0] data_i,
  output logic                          ack_o,
  output logic                          err_o,
  output logic [2:0]                    error_o,
  output logic                          fsm_err_o,
  output logic                          idle_o,
  output logic                          otp_req_o,
  output logic                          otp_cmd_o,
  output logic [AddrWidth-1:0]          otp_addr_o,
  output logic [WordWidth-1:0]          otp_wdata_o,
  input  logic                          otp_gnt_i,
  input  logic                          otp_rvalid_i,
  input  logic [WordWidth-1:0]          otp_rdata_i,
  input  logic [2:0]                    otp_err_i
);

  localparam int              CntW     = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam logic [CntW-1:0] LastIdx  = CntW'(NumWords - 1);
  localparam logic [2:0]      MaxRetry = 3'(MaxRetries);
  localparam logic [3:0]      EscOff   = 4'b1010;
  localparam logic [2:0]      CheckFailError = 3'd6;
  localparam logic [2:0]      FsmStateError  = 3'd7;
  localparam logic [14:0]     Mask     = 15'h2b4d;

  // Five-fold repetition of a 3-bit index keeps every pair of codes >= 5 bits apart.
  typedef enum logic [14:0] {
    ResetSt     = {5{3'd0}} ^ Mask,
    IdleSt      = {5{3'd1}} ^ Mask,
    ScanSt      = {5{3'd2}} ^ Mask,
    WriteSt     = {5{3'd3}} ^ Mask,
    WriteWaitSt = {5{3'd4}} ^ Mask,
    ReadSt      = {5{3'd5}} ^ Mask,
    ReadWaitSt  = {5{3'd6}} ^ Mask,
    ErrorSt     = {5{3'd7}} ^ Mask
  } state_e;

  state_e          state;
  logic [CntW-1:0] cnt;
  logic [CntW-1:0] cnt_n;
  logic [2:0]      retry;
  logic            err_flag;
  logic [2:0]      error_code;
  logic            ack;
  logic            err_out;
  logic            fsm_err;
  logic            idle;
  logic            req;
  logic            cmd;

  logic [WordWidth-1:0] cur_word;
  logic [CntW-1:0]      cnt_inc;
  logic                 last;
  logic                 state_ok;
  logic                 fault;
  logic                 advance;
  logic                 rec_err;
  logic [2:0]           rec_code;
  logic                 err_flag_next;

  always_comb begin
    cur_word = '0;
    for (int k = 0; k < NumWords; k++) begin
      if (cnt == CntW'(k)) cur_word = data_i[k*WordWidth +: WordWidth];
    end
  end

  assign cnt_inc = cnt + 1'b1;
  assign last    = (cnt == LastIdx);

  always_comb begin
    state_ok = 1'b0;
    case (state)
      ResetSt, IdleSt, ScanSt, WriteSt, WriteWaitSt,
      ReadSt, ReadWaitSt, ErrorSt: state_ok = 1'b1;
      default:                     state_ok = 1'b0;
    endcase
  end

  // Escalation, a shadow-counter disagreement and an undecoded state are all fatal.
  assign fault = (escalate_en_i != EscOff) || (cnt != ~cnt_n) || !state_ok;

  always_comb begin
    advance  = 1'b0;
    rec_err  = 1'b0;
    rec_code = '0;
    case (state)
      ScanSt: advance = (cur_word == '0);
      WriteWaitSt: begin
        if (otp_rvalid_i) begin
          if (otp_err_i != '0) begin
            rec_err  = 1'b1;
            rec_code = otp_err_i;
            advance  = 1'b1;
          end else if (!VerifyEn) begin
            advance = 1'b1;
          end
        end
      end
      ReadWaitSt: begin
        if (otp_rvalid_i) begin
          if (otp_err_i != '0) begin
            rec_err  = 1'b1;
            rec_code = otp_err_i;
            advance  = 1'b1;
          end else if (otp_rdata_i == cur_word) begin
            advance = 1'b1;
          end else if (retry >= MaxRetry) begin
            rec_err  = 1'b1;
            rec_code = CheckFailError;
            advance  = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign err_flag_next = err_flag | rec_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ResetSt;
      cnt        <= '0;
      cnt_n      <= '1;
      retry      <= '0;
      err_flag   <= 1'b0;
      error_code <= '0;
      ack        <= 1'b0;
      err_out    <= 1'b0;
      fsm_err    <= 1'b0;
      idle       <= 1'b0;
      req        <= 1'b0;
      cmd        <= 1'b0;
    end else begin
      ack     <= 1'b0;
      err_out <= 1'b0;
      fsm_err <= 1'b0;
      if (fault) begin
        state   <= ErrorSt;
        fsm_err <= (state != ErrorSt);
        req     <= 1'b0;
        cmd     <= 1'b0;
        idle    <= 1'b1;
        if (error_code == '0) error_code <= FsmStateError;
      end else begin
        if (rec_err) begin
          err_flag <= 1'b1;
          if (error_code == '0) error_code <= rec_code;
        end
        if (advance) begin
          retry <= '0;
          if (last) begin
            ack     <= 1'b1;
            err_out <= err_flag_next;
            idle    <= 1'b1;
            state   <= err_flag_next ? ErrorSt : IdleSt;
          end else begin
            cnt   <= cnt_inc;
            cnt_n <= ~cnt_inc;
            state <= ScanSt;
          end
        end else begin
          case (state)
            ResetSt: begin
              if (en_i) begin
                state <= IdleSt;
                idle  <= 1'b1;
              end
            end
            IdleSt: begin
              if (req_i) begin
                state    <= ScanSt;
                cnt      <= '0;
                cnt_n    <= '1;
                retry    <= '0;
                err_flag <= 1'b0;
                idle     <= 1'b0;
              end
            end
            ScanSt: begin
              state <= WriteSt;
              req   <= 1'b1;
              cmd   <= 1'b1;
            end
            WriteSt: begin
              if (otp_gnt_i) begin
                state <= WriteWaitSt;
                req   <= 1'b0;
                cmd   <= 1'b0;
              end
            end
            WriteWaitSt: begin
              if (otp_rvalid_i) begin
                state <= ReadSt;
                req   <= 1'b1;
                cmd   <= 1'b0;
              end
            end
            ReadSt: begin
              if (otp_gnt_i) begin
                state <= ReadWaitSt;
                req   <= 1'b0;
              end
            end
            ReadWaitSt: begin
              if (otp_rvalid_i) begin
                retry <= retry + 3'd1;
                state <= WriteSt;
                req   <= 1'b1;
                cmd   <= 1'b1;
              end
            end
            ErrorSt: begin
              idle <= 1'b1;
              if (error_code == '0) error_code <= FsmStateError;
            end
            default: state <= ErrorSt;
          endcase
        end
      end
    end
  end

  assign ack_o       = ack;
  assign err_o       = err_out;
  assign error_o     = error_code;
  assign fsm_err_o   = fsm_err;
  assign idle_o      = idle;
  assign otp_req_o   = req;
  assign otp_cmd_o   = cmd;
  assign otp_addr_o  = BaseAddr + AddrWidth'(cnt);
  assign otp_wdata_o = (req && cmd) ? cur_word : '0;

endmodule

// File: tb/tb_otp_ctrl_lci_multi.sv
// Bench for otp_ctrl_lci_multi: OTP responder, transaction-level reference model,
// vector table, randomized payloads and hand-written corner sequences.
module tb_otp_ctrl_lci_multi;

  localparam int         NW     = 4;
  localparam int         MR     = 2;
  localparam logic [9:0] BASE   = 10'h040;
  localparam logic [3:0] EscOff = 4'b1010;

  typedef struct packed {
    logic        cmd;
    logic [9:0]  addr;
    logic [15:0] data;
  } txn_t;

  typedef struct {
    string               name;
    logic [NW-1:0][15:0] w;
    logic [NW-1:0][2:0]  werr;
    logic [NW-1:0][1:0]  bad;
    bit                  flag;
    logic [2:0]          code;
    int                  nw;
    int                  nr;
    int                  lat;
  } vec_t;

  logic                 clk, rst_n, en, req;
  logic [3:0]           esc;
  logic [NW*16-1:0]     data;
  logic                 ack, err, fsm_err, idle, otp_req, otp_cmd;
  logic [2:0]           error;
  logic [9:0]           otp_addr;
  logic [15:0]          otp_wdata, otp_rdata;
  logic                 otp_gnt, otp_rvalid;
  logic [2:0]           otp_err;

  int   tests = 0;
  int   fails = 0;
  vec_t tbl[5];
  vec_t cur;
  int   case_id = 0;
  int   log_base = 0;
  txn_t log_q[$];
  txn_t exp_q[$];
  bit   exp_flag;
  logic [2:0] exp_code;
  int   wdata_leak = 0;

  otp_ctrl_lci_multi #(
    .NumWords(NW), .WordWidth(16), .AddrWidth(10), .BaseAddr(BASE),
    .VerifyEn(1'b1), .MaxRetries(MR)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .escalate_en_i(esc), .req_i(req),
    .data_i(data), .ack_o(ack), .err_o(err), .error_o(error), .fsm_err_o(fsm_err),
    .idle_o(idle), .otp_req_o(otp_req), .otp_cmd_o(otp_cmd), .otp_addr_o(otp_addr),
    .otp_wdata_o(otp_wdata), .otp_gnt_i(otp_gnt), .otp_rvalid_i(otp_rvalid),
    .otp_rdata_i(otp_rdata), .otp_err_i(otp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // OTP macro stand-in: grant at once, answer one cycle later; reads of a word
  // return a corrupted value for the first cur.bad[word] reads of each case.
  initial begin
    logic [15:0] mem [1024];
    int   rd_cnt [NW];
    int   case_seen;
    int   idx;
    bit   pending;
    logic [2:0]  p_err;
    logic [15:0] p_rdata;
    pending = 1'b0; p_err = '0; p_rdata = '0; case_seen = -1;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int i = 0; i < NW; i++) rd_cnt[i] = 0;
    otp_gnt = 1'b0; otp_rvalid = 1'b0; otp_rdata = '0; otp_err = '0;
    forever begin
      @(negedge clk);
      otp_gnt = 1'b0; otp_rvalid = 1'b0; otp_rdata = '0; otp_err = '0;
      if (case_seen != case_id) begin
        case_seen = case_id;
        for (int i = 0; i < NW; i++) rd_cnt[i] = 0;
      end
      if (!otp_req && otp_wdata != '0) wdata_leak++;
      if (!rst_n) begin
        pending = 1'b0;
      end else if (pending) begin
        otp_rvalid = 1'b1; otp_err = p_err; otp_rdata = p_rdata; pending = 1'b0;
      end else if (otp_req) begin
        idx = int'(otp_addr) - int'(BASE);
        otp_gnt = 1'b1;
        log_q.push_back('{otp_cmd, otp_addr, otp_wdata});
        p_err = '0; p_rdata = '0;
        if (otp_cmd) begin
          mem[otp_addr] = otp_wdata;
          if (idx >= 0 && idx < NW) p_err = cur.werr[idx];
        end else begin
          p_rdata = mem[otp_addr];
          if (idx >= 0 && idx < NW) begin
            if (rd_cnt[idx] < int'(cur.bad[idx])) p_rdata = p_rdata ^ 16'h0001;
            rd_cnt[idx]++;
          end
        end
        pending = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic note(input logic [2:0] c);
    exp_flag = 1'b1;
    if (exp_code == '0) exp_code = c;
  endtask

  // Expected transaction stream: per non-blank word, up to MR+1 write/read rounds.
  task automatic build_model();
    int left;
    exp_q.delete(); exp_flag = 1'b0; exp_code = '0;
    for (int k = 0; k < NW; k++) begin
      if (cur.w[k] == '0) continue;
      left = int'(cur.bad[k]);
      for (int a = 0; a <= MR; a++) begin
        exp_q.push_back('{1'b1, 10'(int'(BASE) + k), cur.w[k]});
        if (cur.werr[k] != '0) begin note(cur.werr[k]); break; end
        exp_q.push_back('{1'b0, 10'(int'(BASE) + k), 16'h0000});
        if (left == 0) break;
        left--;
        if (a == MR) note(3'd6);
      end
    end
  endtask

  task automatic setup();
    data = cur.w;
    case_id++;
    log_base = log_q.size();
    build_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 1'b0; esc = EscOff; en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
  endtask

  task automatic count_reqs(input int n, output int reqs);
    reqs = 0;
    req = 1'b1;
    repeat (n) begin
      @(negedge clk); #1;
      if (otp_req) reqs++;
    end
    req = 1'b0;
  endtask

  task automatic run_one();
    int cyc, nwr, nrd, extra, reqs;
    bit got;
    logic e;
    logic [2:0] code;
    do_reset();
    setup();
    req = 1'b1;
    got = 1'b0; cyc = 0; e = 1'b0; code = '0;
    while (!got && cyc < 400) begin
      @(negedge clk); #1;
      cyc++;
      req = 1'b0;
      if (ack) begin got = 1'b1; e = err; code = error; end
    end
    check({cur.name, ":ack"}, 32'(got), 32'd1);
    check({cur.name, ":err_o"}, 32'(e), 32'(exp_flag));
    check({cur.name, ":error_o"}, 32'(code), 32'(exp_code));
    check({cur.name, ":idle"}, 32'(idle), 32'd1);
    if (cur.lat >= 0) check({cur.name, ":latency"}, 32'(cyc), 32'(cur.lat));
    check({cur.name, ":n_txn"}, 32'(log_q.size() - log_base), 32'(exp_q.size()));
    nwr = 0; nrd = 0;
    for (int i = log_base; i < log_q.size(); i++) begin
      if (log_q[i].cmd) nwr++; else nrd++;
      if (i - log_base < exp_q.size())
        check($sformatf("%s:txn%0d", cur.name, i - log_base), 32'(log_q[i]), 32'(exp_q[i - log_base]));
    end
    if (cur.nw >= 0) begin
      check({cur.name, ":tbl_err_o"}, 32'(e), 32'(cur.flag));
      check({cur.name, ":tbl_error_o"}, 32'(code), 32'(cur.code));
      check({cur.name, ":tbl_writes"}, 32'(nwr), 32'(cur.nw));
      check({cur.name, ":tbl_reads"}, 32'(nrd), 32'(cur.nr));
    end
    extra = 0;
    repeat (6) begin
      @(negedge clk); #1;
      if (ack) extra++;
    end
    check({cur.name, ":single_ack"}, 32'(extra), 32'd0);
    if (exp_flag) begin
      count_reqs(10, reqs);
      check({cur.name, ":error_state_quiet"}, 32'(reqs), 32'd0);
    end
  endtask

  task automatic wait_grant(input logic want_cmd, output bit found);
    int cyc;
    found = 1'b0; cyc = 0;
    while (!found && cyc < 100) begin
      @(negedge clk); #1;
      cyc++;
      req = 1'b0;
      if (otp_gnt && otp_req && otp_cmd == want_cmd) found = 1'b1;
    end
  endtask

  initial begin
    bit   found;
    int   reqs, cyc, acks;
    bit   e1, e2;

    tbl[0] = '{"clean", {16'h8000, 16'hBEEF, 16'h0000, 16'h0001}, '0, '0,
               1'b0, 3'd0, 3, 3, -1};
    tbl[1] = '{"retry_ok", {16'h8000, 16'hBEEF, 16'h0000, 16'h0001}, '0,
               {2'd0, 2'd2, 2'd0, 2'd0}, 1'b0, 3'd0, 5, 5, -1};
    tbl[2] = '{"retry_fail", {16'h8000, 16'hBEEF, 16'h0000, 16'h0001}, '0,
               {2'd0, 2'd3, 2'd0, 2'd0}, 1'b1, 3'd6, 5, 5, -1};
    tbl[3] = '{"otp_err", {16'h8000, 16'hBEEF, 16'h0000, 16'h0001},
               {3'd4, 3'd0, 3'd0, 3'd2}, '0, 1'b1, 3'd2, 3, 1, -1};
    tbl[4] = '{"all_zero", '0, '0, '0, 1'b0, 3'd0, 0, 0, NW + 1};

    cur = tbl[0];
    rst_n = 1'b0; en = 1'b0; esc = EscOff; req = 1'b0; data = '0;
    #12;
    check("rst:ack", 32'(ack), 32'd0);
    check("rst:err", 32'(err), 32'd0);
    check("rst:error", 32'(error), 32'd0);
    check("rst:fsm_err", 32'(fsm_err), 32'd0);
    check("rst:idle", 32'(idle), 32'd0);
    check("rst:otp_req", 32'(otp_req), 32'd0);
    check("rst:otp_cmd", 32'(otp_cmd), 32'd0);
    check("rst:addr", 32'(otp_addr), 32'(BASE));
    check("rst:wdata", 32'(otp_wdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_st_holds_without_en", 32'(idle), 32'd0);
    en = 1'b1;
    @(negedge clk); #1;
    check("enable_to_idle", 32'(idle), 32'd1);

    for (int i = 0; i < 5; i++) begin
      cur = tbl[i];
      run_one();
    end

    for (int i = 0; i < 20; i++) begin
      cur.name = $sformatf("rand%0d", i);
      for (int k = 0; k < NW; k++) begin
        cur.w[k]    = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
        cur.werr[k] = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
        cur.bad[k]  = 2'($urandom_range(0, 3));
      end
      cur.flag = 1'b0; cur.code = '0; cur.nw = -1; cur.nr = -1; cur.lat = -1;
      run_one();
    end

    // Back-to-back: request held high across the ack restarts immediately.
    cur = tbl[0];
    do_reset();
    setup();
    req = 1'b1;
    acks = 0; cyc = 0; e1 = 1'b1; e2 = 1'b1;
    while (acks < 2 && cyc < 400) begin
      @(negedge clk); #1;
      cyc++;
      if (ack) begin
        acks++;
        if (acks == 1) begin
          e1 = err;
          @(negedge clk); #1;
          cyc++;
          check("b2b:restart_leaves_idle", 32'(idle), 32'd0);
        end else begin
          e2 = err;
          req = 1'b0;
        end
      end
    end
    req = 1'b0;
    check("b2b:acks", 32'(acks), 32'd2);
    check("b2b:err1", 32'(e1), 32'd0);
    check("b2b:err2", 32'(e2), 32'd0);
    check("b2b:n_txn", 32'(log_q.size() - log_base), 32'(2 * exp_q.size()));

    // Escalation while waiting for a write response.
    cur = tbl[0];
    do_reset();
    setup();
    req = 1'b1;
    wait_grant(1'b1, found);
    check("esc:write_grant_seen", 32'(found), 32'd1);
    @(negedge clk); #1;
    esc = 4'b0000;
    @(negedge clk); #1;
    check("esc:fsm_err", 32'(fsm_err), 32'd1);
    check("esc:error", 32'(error), 32'd7);
    check("esc:otp_req", 32'(otp_req), 32'd0);
    check("esc:idle", 32'(idle), 32'd1);
    check("esc:no_ack", 32'(ack), 32'd0);
    @(negedge clk); #1;
    check("esc:fsm_err_pulse", 32'(fsm_err), 32'd0);
    count_reqs(10, reqs);
    check("esc:quiet", 32'(reqs), 32'd0);
    esc = EscOff;

    // Shadow counter disagreement.
    cur = tbl[0];
    do_reset();
    setup();
    force dut.cnt_n = '0;
    @(negedge clk); #1;
    check("shadow:fsm_err", 32'(fsm_err), 32'd1);
    check("shadow:error", 32'(error), 32'd7);
    check("shadow:idle", 32'(idle), 32'd1);
    release dut.cnt_n;
    count_reqs(10, reqs);
    check("shadow:quiet", 32'(reqs), 32'd0);

    // Asynchronous reset while a read response is being returned.
    cur = tbl[0];
    do_reset();
    setup();
    req = 1'b1;
    wait_grant(1'b0, found);
    check("rst_mid:read_grant_seen", 32'(found), 32'd1);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid:otp_req", 32'(otp_req), 32'd0);
    check("rst_mid:otp_cmd", 32'(otp_cmd), 32'd0);
    check("rst_mid:ack", 32'(ack), 32'd0);
    check("rst_mid:idle", 32'(idle), 32'd0);
    check("rst_mid:error", 32'(error), 32'd0);
    check("rst_mid:addr", 32'(otp_addr), 32'(BASE));
    check("rst_mid:wdata", 32'(otp_wdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_mid:recovers_idle", 32'(idle), 32'd1);
    check("rst_mid:no_stray_ack", 32'(ack), 32'd0);

    check("wdata_gated_when_idle", 32'(wdata_leak), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/otp_ctrl_lci_multi.md
Name: otp_ctrl_lci_multi

Overview:
- Parametrised successor to the life cycle programming interface in otp_ctrl.
- Burns an N-word life cycle payload into OTP, one native word per transaction.
- Adds two features:
  - Blank-word skipping: all-zero words are not programmed.
  - Optional read-back verify with bounded retries per word.
- Sits between lc_ctrl's transition request port and the OTP macro arbiter.

Parameters:
- NumWords, 12, number of native OTP words in the payload (>=2).
- WordWidth, 16, native OTP word width in bits.
- AddrWidth, 10, OTP word address width.
- BaseAddr, 0, word address of payload word 0 (AddrWidth bits).
- VerifyEn, 1, 1 = read back and compare each written word; 0 = write only.
- MaxRetries, 2, extra write attempts per word after a verify mismatch (0..7).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- en_i  in  1  enable; leaves ResetSt.
- escalate_en_i  in  4  lc_tx_t escalation.
- req_i  in  1  transition request; level, sampled in IdleSt.
- data_i  in  NumWords*WordWidth  payload; word k = data_i[k*WordWidth +: WordWidth]; must stay stable while busy.
- ack_o  out  1  one-cycle completion pulse.
- err_o  out  1  asserted with ack_o if any error occurred.
- error_o  out  3  latched otp_err code.
- fsm_err_o  out  1  pulse on glitch/escalation/counter fault.
- idle_o  out  1  high in IdleSt and ErrorSt.
- otp_req_o  out  1  OTP request.
- otp_cmd_o  out  1  0 = Read, 1 = Write.
- otp_addr_o  out  AddrWidth  BaseAddr + cnt.
- otp_wdata_o  out  WordWidth  word[cnt] while otp_req_o && Write, else 0.
- otp_gnt_i  in  1  grant.
- otp_rvalid_i  in  1  response valid.
- otp_rdata_i  in  WordWidth  read data.
- otp_err_i  in  3  response code; 0 = NoError.

Behaviour:
- Reset values: state = ResetSt, error_q = 0, cnt = 0, retry = 0. All outputs 0 except otp_addr_o = BaseAddr.
- States use a sparse encoding with minimum Hamming distance 5. Any undecoded value goes to ErrorSt and pulses fsm_err_o.
- ResetSt: goes to IdleSt when en_i = 1.
- IdleSt: on req_i, clear cnt, retry and a per-request err flag, then go to ScanSt.
- ScanSt (1 cycle, no OTP access):
  - If word[cnt] == 0, skip it: advance to the next word, or finish if cnt == NumWords-1.
  - Otherwise go to WriteSt.
- WriteSt: otp_req_o = 1, cmd = Write; on otp_gnt_i go to WriteWaitSt.
- WriteWaitSt: on otp_rvalid_i:
  - If otp_err_i != 0, record the error and advance with no verify.
  - Else if VerifyEn, go to ReadSt.
  - Else advance.
- ReadSt: otp_req_o = 1, cmd = Read; on otp_gnt_i go to ReadWaitSt.
- ReadWaitSt: on otp_rvalid_i:
  - If otp_err_i != 0, record the error and advance.
  - Else if otp_rdata_i == word[cnt], advance.
  - Else if retry < MaxRetries, increment retry and go to WriteSt.
  - Else record code 6 (CheckFailError) and advance.
- Advance: retry = 0. If cnt == NumWords-1, finish; otherwise cnt += 1 and go to ScanSt.
- Finish: ack_o = 1 that cycle.
  - err flag clear: err_o = 0, go to IdleSt.
  - err flag set: err_o = 1, go to ErrorSt.
- Error recording: sets the err flag. error_q is written only while error_q == 0, so the first error is sticky; later codes do not overwrite it.
- ErrorSt: terminal. If error_q == 0, load 7 (FsmStateError). No further OTP requests or acks.
- Escalation: escalate_en_i != 4'b1010 (lc_tx loose true) overrides everything. Go to ErrorSt, pulse fsm_err_o, load 7 if error_q == 0.
- Counter integrity:
  - cnt is duplicated as a primary counter and an inverted shadow.
  - A mismatch behaves like escalation.
  - cnt saturates at NumWords-1 and never wraps.
- Back-to-back: req_i held high after ack starts a new request one cycle later from IdleSt.
- Reset mid-operation: returns to ResetSt immediately and drops otp_req_o. Any OTP response arriving after reset is ignored.
- otp_req_o stays asserted until granted; the address and data are stable while it is asserted.

Test Plan:
- NumWords = 4, VerifyEn = 1, data words {0x0001, 0x0000, 0xBEEF, 0x8000}, all responses clean, rdata echoes the written word -> 3 writes and 3 reads at addresses BaseAddr+{0,2,3}, no access at +1, one ack_o, err_o = 0, back in IdleSt.
- Word 2 read back as 0xBEEE twice, then 0xBEEF (MaxRetries = 2) -> 3 writes to BaseAddr+2, ack_o with err_o = 0. With 3 mismatches -> err_o = 1, error_o = 6, ErrorSt.
- otp_err_i = 2 on word 0's write, then 4 on word 3's write -> all remaining words still written, error_o = 2 (first error sticky), ack_o with err_o = 1.
- escalate_en_i = 4'b0000 while in WriteWaitSt -> next cycle in ErrorSt, fsm_err_o pulses, error_o = 7, otp_req_o stays 0 thereafter.
- Force the state register to an illegal code, or force a shadow counter mismatch -> ErrorSt, fsm_err_o = 1, error_o = 7.
- All-zero payload -> NumWords ScanSt cycles, zero OTP requests, ack_o = 1, err_o = 0. Reset asserted during ReadWaitSt -> all outputs return to reset values asynchronously.
